// File: rtl/game_pkg.sv
// Shared game types and constants: player identities, attack-unit state encoding,
// board geometry and the LFSR seed.
package game_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10
  } player_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AIM,
    ST_EXPIRED,
    ST_SHOT
  } atk_state_t;

  localparam int         BOARD_N   = 5;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/turn_attack_unit_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4); the seed is non-zero so the
// sequence never locks up.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] value
);

  logic [7:0] q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= SEED;
    else     q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

  assign value = q;

endmodule

// File: rtl/turn_attack_unit.sv
// Per-turn attack engine beside the game-control FSM: cursor aiming, turn timer,
// timeout handling and LFSR-driven random shots.
module turn_attack_unit #(
  parameter int TURN_CYCLES = 750000000,
  parameter int BOARD_N     = game_pkg::BOARD_N,
  parameter int CW          = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_attack_p1,
  input  logic          en_attack_p2,
  input  logic          en_attack_random,
  input  logic          en_check,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_fire,
  output logic [CW-1:0] cursor_x,
  output logic [CW-1:0] cursor_y,
  output logic [CW-1:0] attack_x,
  output logic [CW-1:0] attack_y,
  output logic          attack_valid,
  output logic          end_attack_p1,
  output logic          end_attack_p2,
  output logic          timeout,
  output logic [1:0]    current_player
);
  import game_pkg::*;

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  function automatic logic [CW-1:0] step_axis(input logic [CW-1:0] v,
                                              input logic inc, input logic dec);
    if (inc && !dec)      return (v == CW'(BOARD_N - 1)) ? '0 : v + CW'(1);
    else if (dec && !inc) return (v == '0) ? CW'(BOARD_N - 1) : v - CW'(1);
    else                  return v;
  endfunction

  function automatic logic [CW-1:0] fold(input logic [3:0] v);
    return CW'(int'(v) % BOARD_N);
  endfunction

  atk_state_t    state_q, state_d;
  player_t       player_q, player_d, req, shot_player;
  logic [CW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [CW-1:0] atk_x_q, atk_x_d, atk_y_q, atk_y_d, shot_x, shot_y;
  logic [TW-1:0] timer_q, timer_d;
  logic          valid_q, valid_d, end1_q, end1_d, end2_q, end2_d;
  logic          timeout_q, timeout_d, rnd_q;
  logic          start, shoot, rnd_rise;
  logic [7:0]    lfsr;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  // Player 1 wins when both enables are (illegally) high together.
  assign req      = en_attack_p1 ? P1 : (en_attack_p2 ? P2 : NONE);
  // Random shots trigger on the first cycle of the request only, so a held
  // request never produces a second shot.
  assign rnd_rise = en_attack_random && !rnd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      player_q  <= NONE;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      atk_x_q   <= '0;
      atk_y_q   <= '0;
      timer_q   <= '0;
      valid_q   <= 1'b0;
      end1_q    <= 1'b0;
      end2_q    <= 1'b0;
      timeout_q <= 1'b0;
      rnd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      atk_x_q   <= atk_x_d;
      atk_y_q   <= atk_y_d;
      timer_q   <= timer_d;
      valid_q   <= valid_d;
      end1_q    <= end1_d;
      end2_q    <= end2_d;
      timeout_q <= timeout_d;
      rnd_q     <= en_attack_random;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    player_d    = player_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    atk_x_d     = atk_x_q;
    atk_y_d     = atk_y_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;
    valid_d     = 1'b0;
    end1_d      = 1'b0;
    end2_d      = 1'b0;
    start       = 1'b0;
    shoot       = 1'b0;
    shot_x      = cur_x_q;
    shot_y      = cur_y_q;
    shot_player = player_q;

    case (state_q)
      ST_IDLE: begin
        if (req != NONE) start = 1'b1;
        else if (rnd_rise) begin
          shoot       = 1'b1;
          shot_x      = fold(lfsr[3:0]);
          shot_y      = fold(lfsr[7:4]);
          shot_player = P2;
        end
      end
      ST_AIM: begin
        cur_x_d = step_axis(cur_x_q, btn_right, btn_left);
        cur_y_d = step_axis(cur_y_q, btn_down, btn_up);
        if (timer_q != '0) timer_d = timer_q - TW'(1);
        // Fire on the last cycle of the turn still counts as a normal shot.
        if (btn_fire) shoot = 1'b1;
        else if (timer_q == '0) begin
          timeout_d = 1'b1;
          state_d   = ST_EXPIRED;
        end
      end
      ST_EXPIRED: begin
        if (rnd_rise) begin
          shoot  = 1'b1;
          shot_x = fold(lfsr[3:0]);
          shot_y = fold(lfsr[7:4]);
        end
      end
      ST_SHOT: begin
        // Player is held here while the FSM checks the result; only a hand-over
        // to the other side (human or automatic player 2) starts a new shot.
        if (req != NONE && req != player_q) start = 1'b1;
        else if (rnd_rise && player_q != P2) begin
          shoot       = 1'b1;
          shot_x      = fold(lfsr[3:0]);
          shot_y      = fold(lfsr[7:4]);
          shot_player = P2;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d  = ST_AIM;
      player_d = req;
      cur_x_d  = '0;
      cur_y_d  = '0;
      timer_d  = TW'(TURN_CYCLES - 1);
    end
    if (shoot) begin
      state_d   = ST_SHOT;
      player_d  = shot_player;
      atk_x_d   = shot_x;
      atk_y_d   = shot_y;
      valid_d   = 1'b1;
      end1_d    = (shot_player == P1);
      end2_d    = (shot_player == P2);
      timeout_d = 1'b0;
    end
  end

  assign cursor_x       = cur_x_q;
  assign cursor_y       = cur_y_q;
  assign attack_x       = atk_x_q;
  assign attack_y       = atk_y_q;
  assign attack_valid   = valid_q;
  assign end_attack_p1  = end1_q;
  assign end_attack_p2  = end2_q;
  assign timeout        = timeout_q;
  assign current_player = player_q;

endmodule

// File: tb/tb_turn_attack_unit.sv
// Self-checking bench for turn_attack_unit: directed turn scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_turn_attack_unit;

  localparam int TC = 20;
  localparam int BN = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_attack_p1, en_attack_p2, en_attack_random, en_check;
  logic       btn_up, btn_down, btn_left, btn_right, btn_fire;
  logic [2:0] cursor_x, cursor_y, attack_x, attack_y;
  logic       attack_valid, end_attack_p1, end_attack_p2, timeout;
  logic [1:0] current_player;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  turn_attack_unit #(.TURN_CYCLES(TC), .BOARD_N(BN), .CW(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .en_attack_p1     (en_attack_p1),
    .en_attack_p2     (en_attack_p2),
    .en_attack_random (en_attack_random),
    .en_check         (en_check),
    .btn_up           (btn_up),
    .btn_down         (btn_down),
    .btn_left         (btn_left),
    .btn_right        (btn_right),
    .btn_fire         (btn_fire),
    .cursor_x         (cursor_x),
    .cursor_y         (cursor_y),
    .attack_x         (attack_x),
    .attack_y         (attack_y),
    .attack_valid     (attack_valid),
    .end_attack_p1    (end_attack_p1),
    .end_attack_p2    (end_attack_p2),
    .timeout          (timeout),
    .current_player   (current_player)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Turn phases: waiting for a first turn, aiming, out of time, shot delivered.
  localparam int M_IDLE = 0, M_AIM = 1, M_EXPIRED = 2, M_SHOT = 3;
  int         m_mode, m_age, m_req, m_ox, m_oy;
  bit         m_rnd_prev, m_rise;
  logic [7:0] m_lfsr;
  int         e_cx, e_cy, e_ax, e_ay, e_player;
  bit         e_valid, e_end1, e_end2, e_to;

  task model_reset();
    m_mode = M_IDLE; m_age = 0; m_rnd_prev = 1'b0; m_lfsr = 8'hA5;
    e_cx = 0; e_cy = 0; e_ax = 0; e_ay = 0; e_player = 0;
    e_valid = 1'b0; e_end1 = 1'b0; e_end2 = 1'b0; e_to = 1'b0;
  endtask

  task open_turn(input int p);
    e_player = p; e_cx = 0; e_cy = 0; m_age = 0; m_mode = M_AIM;
  endtask

  task issue(input int x, input int y, input int p);
    e_ax = x; e_ay = y; e_valid = 1'b1; e_end1 = (p == 1); e_end2 = (p == 2);
    e_player = p; e_to = 1'b0; m_mode = M_SHOT;
  endtask

  task random_shot(input int p);
    issue(int'(m_lfsr[3:0]) % BN, int'(m_lfsr[7:4]) % BN, p);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      m_req  = en_attack_p1 ? 1 : (en_attack_p2 ? 2 : 0);
      m_rise = en_attack_random && !m_rnd_prev;
      e_valid = 1'b0; e_end1 = 1'b0; e_end2 = 1'b0;
      case (m_mode)
        M_IDLE: if (m_req != 0) open_turn(m_req); else if (m_rise) random_shot(2);
        M_AIM: begin
          m_ox = e_cx; m_oy = e_cy;
          e_cx = (e_cx + int'(btn_right) - int'(btn_left) + BN) % BN;
          e_cy = (e_cy + int'(btn_down) - int'(btn_up) + BN) % BN;
          if (btn_fire) issue(m_ox, m_oy, e_player);
          else if (m_age == TC - 1) begin e_to = 1'b1; m_mode = M_EXPIRED; end
          m_age++;
        end
        M_EXPIRED: if (m_rise) random_shot(e_player);
        default: begin
          if (m_req != 0 && m_req != e_player) open_turn(m_req);
          else if (m_rise && e_player != 2) random_shot(2);
        end
      endcase
      m_rnd_prev = en_attack_random;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      check("cursor_x", 32'(cursor_x), e_cx);
      check("cursor_y", 32'(cursor_y), e_cy);
      check("attack_x", 32'(attack_x), e_ax);
      check("attack_y", 32'(attack_y), e_ay);
      check("attack_valid", 32'(attack_valid), 32'(e_valid));
      check("end_attack_p1", 32'(end_attack_p1), 32'(e_end1));
      check("end_attack_p2", 32'(end_attack_p2), 32'(e_end2));
      check("timeout", 32'(timeout), 32'(e_to));
      check("current_player", 32'(current_player), e_player);
    end
  end

  // ---------------- stimulus ----------------
  task step();
    @(posedge clk);
    #3;
  endtask

  task pulse(input int which);
    case (which)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      2: btn_left = 1'b1;
      3: btn_right = 1'b1;
      default: btn_fire = 1'b1;
    endcase
    step();
    {btn_up, btn_down, btn_left, btn_right, btn_fire} = '0;
  endtask

  task check_all_zero(input string tag);
    check({tag, "_outputs"}, {cursor_x, cursor_y, attack_x, attack_y, attack_valid,
                              end_attack_p1, end_attack_p2, timeout, current_player}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {en_attack_p1, en_attack_p2, en_attack_random, en_check} = '0;
    {btn_up, btn_down, btn_left, btn_right, btn_fire} = '0;
    step(); step();
    check_all_zero("reset");
    rst = 1'b0;
    cmp_on = 1'b1;

    // P1 turn: three right, two down, fire -> (3,2)
    en_attack_p1 = 1'b1; step(); en_attack_p1 = 1'b0;
    check("p1_player", 32'(current_player), 1);
    repeat (3) pulse(3);
    repeat (2) pulse(1);
    pulse(4);
    check("p1_attack_xy", {attack_y, attack_x}, {3'd2, 3'd3});
    check("p1_pulses", {attack_valid, end_attack_p1, end_attack_p2, timeout}, 4'b1100);
    step();
    check("p1_pulses_drop", {attack_valid, end_attack_p1}, 0);

    // Result check keeps the player; hand-over to P2 recentres the cursor
    en_check = 1'b1;
    repeat (3) begin step(); check("check_hold_player", 32'(current_player), 1); end
    en_check = 1'b0;
    en_attack_p2 = 1'b1; step(); en_attack_p2 = 1'b0;
    check("p2_entry", {current_player, cursor_x, cursor_y}, {2'd2, 3'd0, 3'd0});
    pulse(2); check("wrap_left", 32'(cursor_x), 4);
    pulse(0); check("wrap_up", 32'(cursor_y), 4);
    pulse(1); check("wrap_down", 32'(cursor_y), 0);
    pulse(4);
    check("p2_shot", {attack_x, attack_y, end_attack_p2}, {3'd4, 3'd0, 1'b1});

    // P1 fires on the very cycle its timer reaches zero
    en_attack_p1 = 1'b1; step(); en_attack_p1 = 1'b0;
    repeat (TC - 1) step();
    check("edge_no_timeout_yet", 32'(timeout), 0);
    pulse(4);
    check("edge_fire_wins", {attack_valid, end_attack_p1, timeout}, 3'b110);
    step();
    check("edge_timeout_stays_low", 32'(timeout), 0);

    // P2 lets the timer run out, then the FSM requests a random shot
    en_attack_p2 = 1'b1; step(); en_attack_p2 = 1'b0;
    for (int i = 1; i <= TC; i++) begin
      if (timeout !== 1'b0) check("timeout_early", 32'(timeout), 0);
      step();
    end
    check("timeout_rises", 32'(timeout), 1);
    pulse(4);
    check("expired_fire_ignored", {attack_valid, timeout}, 2'b01);
    en_attack_random = 1'b1; step(); en_attack_random = 1'b0;
    check("random_pulses", {attack_valid, end_attack_p1, end_attack_p2, timeout}, 4'b1010);
    check("random_xy", {attack_x, attack_y}, {3'(e_ax), 3'(e_ay)});

    // Both enables together: player 1 chosen
    {en_attack_p1, en_attack_p2} = 2'b11; step(); {en_attack_p1, en_attack_p2} = 2'b00;
    check("both_enables_p1", 32'(current_player), 1);

    // Asynchronous reset mid-turn, then a stray fire without enable
    repeat (5) step();
    pulse(3);
    #4 rst = 1'b1;
    #1 check_all_zero("async_reset");
    step(); rst = 1'b0;
    pulse(4);
    check("stray_fire", {attack_valid, end_attack_p1, end_attack_p2}, 0);

    // Random shot straight from idle: LFSR A5 -> 4A -> 95 gives (0,4) for P2
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    en_attack_random = 1'b1; step(); en_attack_random = 1'b0;
    check("idle_random", {attack_x, attack_y, current_player, end_attack_p2},
          {3'd0, 3'd4, 2'd2, 1'b1});

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      en_attack_p1     = (r < 4) || (r == 8);
      en_attack_p2     = (r >= 4) && (r < 9);
      en_attack_random = ($urandom_range(0, 9) == 0);
      en_check         = ($urandom_range(0, 3) == 0);
      btn_up           = ($urandom_range(0, 3) == 0);
      btn_down         = ($urandom_range(0, 3) == 0);
      btn_left         = ($urandom_range(0, 3) == 0);
      btn_right        = ($urandom_range(0, 3) == 0);
      btn_fire         = ($urandom_range(0, 29) == 0);
      rst              = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_attack_unit.md
Name: turn_attack_unit

Overview:
- Per-turn attack engine sitting directly beside the game-control FSM.
- Consumes the FSM enables en_attack_p1, en_attack_p2, en_attack_random and en_check.
- Produces the FSM inputs end_attack_p1, end_attack_p2, timeout and current_player.
- Drives the attack coordinate toward board memory; handles cursor aiming, per-turn timer and LFSR random shots.

Parameters:
- TURN_CYCLES, 750000000, clock cycles allowed per human turn (15 s at 50 MHz); benches use 20.
- BOARD_N, 5, board side length; coordinates range 0..BOARD_N-1.
- CW, 3, coordinate width in bits; must satisfy 2^CW >= BOARD_N.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- en_attack_p1  in  1  FSM enables player-1 aiming
- en_attack_p2  in  1  FSM enables player-2 aiming
- en_attack_random  in  1  FSM requests an automatic random shot
- en_check  in  1  FSM is in result-check state
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced single-cycle pulses
- btn_fire  in  1  debounced single-cycle pulse
- cursor_x, cursor_y  out  CW each  current aim cell
- attack_x, attack_y  out  CW each  registered coordinate of the last issued shot
- attack_valid  out  1  one-cycle pulse when attack_x/attack_y are updated
- end_attack_p1  out  1  one-cycle pulse: player-1 shot issued
- end_attack_p2  out  1  one-cycle pulse: player-2 shot issued
- timeout  out  1  level: turn timer expired, held until the random shot is issued
- current_player  out  2  00 none, 01 player 1, 10 player 2

Behaviour:
- Reset values: all outputs 0, including current_player=00; state IDLE; timer=0; LFSR=8'hA5 (never zero).
- States: IDLE, AIM, EXPIRED, SHOT.
- IDLE -> AIM:
  - On en_attack_p1 (priority) or en_attack_p2: current_player=01 or 10 respectively.
  - Cursor reset to (0,0); timer loaded with TURN_CYCLES-1.
- AIM:
  - Timer decrements every cycle.
  - Arrow pulses move the cursor one cell with wrap-around at both ends, e.g. left at x=0 -> BOARD_N-1. Simultaneous arrows: each axis handled independently; up+down (or left+right) on the same cycle cancels.
  - btn_fire: next cycle attack_x/y=cursor, attack_valid=1, end_attack_pX=1 for the current player -> SHOT.
  - Timer reaching 0 without fire -> timeout=1 next cycle -> EXPIRED.
  - Fire on the same cycle the timer hits 0: fire wins, timeout stays 0.
  - Enable for the current player drops without fire (FSM wait state): remain in AIM, timer keeps running.
- EXPIRED:
  - timeout held high; arrows and fire ignored.
  - On the first cycle of en_attack_random: x=lfsr[3:0] mod BOARD_N, y=lfsr[7:4] mod BOARD_N.
  - Next cycle: attack_valid=1, end_attack_pX=1 for current_player, timeout cleared -> SHOT.
- en_attack_random while in IDLE (FSM path with single-player mode): shot issued as above with current_player=10.
- SHOT:
  - current_player held unchanged through en_check, because the FSM uses it to pick the next attacker.
  - An enable for the opposite player -> AIM with the new player.
  - end_attack pulses never repeat for one shot.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every cycle regardless of state.
- Fire outside AIM is ignored; a second fire within one turn is ignored.
- en_attack_p1 and en_attack_p2 both high (illegal): player 1 chosen.
- Reset mid-turn: immediate return to IDLE, all pulses and timeout drop asynchronously.
- Timer width: $clog2(TURN_CYCLES) bits; no wrap below 0.

Decomposition:
- Shared package game_pkg holds:
  - player_t enum (NONE=2'b00, P1=2'b01, P2=2'b10);
  - state encoding for this unit;
  - BOARD_N and LFSR seed constants.
- One natural sub-module: lfsr8 (free-running, seeded, exposes 8-bit value).

Test Plan:
- Reset then en_attack_p1=1, 3x btn_right, 2x btn_down, btn_fire -> current_player=01, attack=(3,2), attack_valid and end_attack_p1 pulse exactly one cycle, timeout=0.
- P1 cursor at x=0, btn_left -> cursor_x=4; at y=4, btn_down -> cursor_y=0.
- TURN_CYCLES=20, en_attack_p2, no buttons -> timeout rises on cycle 20 after entry. Then en_attack_random -> coordinates equal the expected LFSR mod 5, end_attack_p2 pulse, timeout falls.
- btn_fire on the exact cycle the timer reaches 0 -> normal shot, timeout never asserts.
- After a P1 shot, assert en_check for 3 cycles -> current_player stays 01. Then en_attack_p2 -> current_player=10, cursor=(0,0).
- Assert rst during AIM with timer mid-count -> all outputs 0 immediately; a fire pulse after reset release without enable -> no attack_valid.
